// File: rtl/b_bcd_encoder.sv
// b_bcd_encoder: sequential binary-to-digit-code encoder.
// Runs one double-dabble iteration per clock, then formats the BCD nibbles
// into 5-bit seven-segment digit codes (0-9 digit, 10 blank, 16 'E').
module b_bcd_encoder #(
    parameter int unsigned WIDTH  = 14,
    parameter int unsigned DIGITS = 4
) (
    input  logic                  Clk,
    input  logic                  nReset,
    input  logic [WIDTH-1:0]      Value,
    input  logic                  Start,
    input  logic                  BlankZeros,
    output logic [5*DIGITS-1:0]   Digits,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Overflow
);

    // Largest value representable in DIGITS decimal digits.
    function automatic int unsigned pow10(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned k = 0; k < n; k++) begin
            r = r * 10;
        end
        return r;
    endfunction

    localparam int unsigned BCD_W    = 4 * DIGITS;
    localparam int unsigned CODE_W   = 5;
    localparam int unsigned STEP_W   = BCD_W + WIDTH;
    localparam int unsigned CNT_W    = $clog2(WIDTH + 1);
    localparam int unsigned MAX_VAL  = pow10(DIGITS) - 1;

    localparam logic [CODE_W-1:0] CODE_BLANK = CODE_W'(10);
    localparam logic [CODE_W-1:0] CODE_ERR   = CODE_W'(16);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONVERT,
        S_FORMAT
    } state_e;

    state_e                 state_q;
    logic [WIDTH-1:0]       shift_q;
    logic [BCD_W-1:0]       bcd_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   blank_q;
    logic                   ovf_q;
    logic [5*DIGITS-1:0]    digits_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   overflow_q;

    logic [BCD_W-1:0]       adj_c;
    logic [BCD_W-1:0]       bcd_d;
    logic [WIDTH-1:0]       shift_d;
    logic [5*DIGITS-1:0]    digits_d;
    logic [3:0]             nib_c;
    logic [CODE_W-1:0]      code_c;
    logic                   seen_c;

    // One double-dabble step: add 3 to every nibble >= 5, then shift left.
    // The bit leaving the BCD MSB only exists for overflowing values and is dropped.
    always_comb begin
        adj_c = bcd_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj_c[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        {bcd_d, shift_d} = STEP_W'({adj_c, shift_q} << 1);
    end

    // Map finished BCD nibbles to digit codes, blanking leading zeros above the units digit.
    always_comb begin
        digits_d = '0;
        nib_c    = '0;
        code_c   = '0;
        seen_c   = 1'b0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            nib_c = bcd_q[4*(DIGITS-1-k) +: 4];
            if (ovf_q) begin
                code_c = CODE_ERR;
            end else if (blank_q && !seen_c && (nib_c == 4'd0) && (k != DIGITS - 1)) begin
                code_c = CODE_BLANK;
            end else begin
                code_c = {1'b0, nib_c};
            end
            if (nib_c != 4'd0) begin
                seen_c = 1'b1;
            end
            digits_d[5*(DIGITS-1-k) +: 5] = code_c;
        end
    end

    // Control FSM with datapath and registered outputs.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            blank_q    <= 1'b0;
            ovf_q      <= 1'b0;
            digits_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (Start) begin
                        shift_q <= Value;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        blank_q <= BlankZeros;
                        ovf_q   <= (32'(Value) > MAX_VAL);
                        busy_q  <= 1'b1;
                        state_q <= S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    bcd_q   <= bcd_d;
                    shift_q <= shift_d;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_q <= S_FORMAT;
                    end
                end
                S_FORMAT: begin
                    digits_q   <= digits_d;
                    overflow_q <= ovf_q;
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign Digits   = digits_q;
    assign Busy     = busy_q;
    assign Done     = done_q;
    assign Overflow = overflow_q;

endmodule

// File: tb/tb_b_bcd_encoder.sv
// Testbench for b_bcd_encoder: scoreboard of expected conversions popped on Done.
module tb_b_bcd_encoder;

    localparam int unsigned W    = 14;
    localparam int unsigned D    = 4;
    localparam int unsigned LAT  = W + 1;
    localparam int unsigned MAXV = 9999;

    logic             Clk = 1'b0;
    logic             nReset = 1'b0;
    logic [W-1:0]     Value = '0;
    logic             Start = 1'b0;
    logic             BlankZeros = 1'b0;
    logic [5*D-1:0]   Digits;
    logic             Busy;
    logic             Done;
    logic             Overflow;

    b_bcd_encoder #(.WIDTH(W), .DIGITS(D)) dut (
        .Clk        (Clk),
        .nReset     (nReset),
        .Value      (Value),
        .Start      (Start),
        .BlankZeros (BlankZeros),
        .Digits     (Digits),
        .Busy       (Busy),
        .Done       (Done),
        .Overflow   (Overflow)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [5*D-1:0] digits;
        logic           ovf;
        int             start_cyc;
    } exp_t;

    exp_t           exp_q[$];
    int             n_checks = 0;
    int             n_errors = 0;
    int             cyc = 0;
    int             done_count = 0;
    int             last_done_cyc = 0;
    bit             mon_en = 1'b0;
    logic [5*D-1:0] hold_digits = '0;
    logic           hold_ovf = 1'b0;
    logic           done_prev = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Decimal reference: digit codes for value v with optional leading-zero blanking.
    function automatic logic [5*D-1:0] ref_digits(input int unsigned v, input bit b);
        logic [5*D-1:0] r;
        int unsigned    rem;
        r = '0;
        if (v > MAXV) begin
            for (int i = 0; i < int'(D); i++) r[5*i +: 5] = 5'd16;
            return r;
        end
        rem = v;
        for (int i = 0; i < int'(D); i++) begin
            r[5*i +: 5] = 5'(rem % 10);
            rem = rem / 10;
        end
        if (b) begin
            for (int i = int'(D) - 1; i > 0; i--) begin
                if (r[5*i +: 5] != 5'd0) break;
                r[5*i +: 5] = 5'd10;
            end
        end
        return r;
    endfunction

    // Cycle counter, stepped on every active edge.
    initial begin
        forever begin
            @(posedge Clk);
            cyc++;
        end
    end

    // Output monitor: compares on Done, checks stability and Busy otherwise.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (mon_en) begin
                if (Done) begin
                    check_eq("done_one_cycle", 32'(done_prev), 32'd0);
                    if (exp_q.size() == 0) begin
                        check_eq("done_expected", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("digits", 32'(Digits), 32'(e.digits));
                        check_eq("overflow", 32'(Overflow), 32'(e.ovf));
                        check_eq("latency", 32'(cyc - e.start_cyc), 32'(LAT));
                        hold_digits = e.digits;
                        hold_ovf    = e.ovf;
                    end
                    done_count++;
                    last_done_cyc = cyc;
                end else begin
                    check_eq("digits_stable", 32'(Digits), 32'(hold_digits));
                    check_eq("ovf_stable", 32'(Overflow), 32'(hold_ovf));
                end
                check_eq("busy", 32'(Busy), 32'(exp_q.size() != 0));
            end
            done_prev = Done;
        end
    end

    task automatic push_exp(input int unsigned v, input bit b);
        exp_t e;
        e.digits    = ref_digits(v, b);
        e.ovf       = (v > MAXV);
        e.start_cyc = cyc;
        exp_q.push_back(e);
    endtask

    task automatic start_conv(input int unsigned v, input bit b);
        @(negedge Clk);
        Value      = W'(v);
        BlankZeros = b;
        Start      = 1'b1;
        @(posedge Clk);
        #1;
        push_exp(v, b);
        Start      = 1'b0;
        Value      = W'($urandom);
        BlankZeros = 1'($urandom);
    endtask

    task automatic wait_done(input string tag);
        int n;
        int k;
        n = done_count;
        k = 0;
        while (done_count == n && k < 60) begin
            @(negedge Clk);
            #1;
            k++;
        end
        check_eq(tag, 32'(done_count - n), 32'd1);
    endtask

    task automatic run(input int unsigned v, input bit b);
        start_conv(v, b);
        wait_done("done_seen");
    endtask

    initial begin
        int n0;
        int first_done;

        // Reset state
        nReset = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check_eq("rst_digits", 32'(Digits), 32'd0);
        check_eq("rst_busy", 32'(Busy), 32'd0);
        check_eq("rst_done", 32'(Done), 32'd0);
        check_eq("rst_ovf", 32'(Overflow), 32'd0);
        @(negedge Clk);
        nReset = 1'b1;
        mon_en = 1'b1;

        // Directed values
        run(1234, 1'b0);
        check_eq("d1234", 32'(Digits), 32'({5'd1, 5'd2, 5'd3, 5'd4}));
        check_eq("ovf1234", 32'(Overflow), 32'd0);
        run(42, 1'b1);
        check_eq("d42_blank", 32'(Digits), 32'({5'd10, 5'd10, 5'd4, 5'd2}));
        run(0, 1'b1);
        check_eq("d0_blank", 32'(Digits), 32'({5'd10, 5'd10, 5'd10, 5'd0}));
        run(0, 1'b0);
        check_eq("d0", 32'(Digits), 32'd0);
        run(9999, 1'b0);
        check_eq("d9999", 32'(Digits), 32'({5'd9, 5'd9, 5'd9, 5'd9}));
        check_eq("ovf9999", 32'(Overflow), 32'd0);
        run(10000, 1'b1);
        check_eq("d10000", 32'(Digits), 32'({5'd16, 5'd16, 5'd16, 5'd16}));
        check_eq("ovf10000", 32'(Overflow), 32'd1);
        run(7, 1'b0);
        check_eq("d7", 32'(Digits), 32'({5'd0, 5'd0, 5'd0, 5'd7}));
        check_eq("ovf7", 32'(Overflow), 32'd0);

        // Start while busy is ignored
        start_conv(5678, 1'b0);
        repeat (4) @(negedge Clk);
        Value = W'(1);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        n0 = done_count;
        wait_done("done_5678");
        check_eq("d5678", 32'(Digits), 32'({5'd5, 5'd6, 5'd7, 5'd8}));
        repeat (20) @(negedge Clk);
        #1;
        check_eq("single_done", 32'(done_count - n0), 32'd1);

        // Start held across Done: back-to-back conversion
        @(negedge Clk);
        Value      = W'(321);
        BlankZeros = 1'b0;
        Start      = 1'b1;
        @(posedge Clk);
        #1;
        push_exp(321, 1'b0);
        Value      = W'(45);
        BlankZeros = 1'b1;
        wait_done("done_held1");
        first_done = last_done_cyc;
        check_eq("d321", 32'(Digits), 32'({5'd0, 5'd3, 5'd2, 5'd1}));
        @(posedge Clk);
        #1;
        push_exp(45, 1'b1);
        Start = 1'b0;
        wait_done("done_held2");
        check_eq("b2b_spacing", 32'(last_done_cyc - first_done), 32'(W + 2));
        check_eq("d45_blank", 32'(Digits), 32'({5'd10, 5'd10, 5'd4, 5'd5}));

        // Reset in the middle of a conversion
        run(12345, 1'b0);
        check_eq("ovf12345", 32'(Overflow), 32'd1);
        start_conv(2468, 1'b0);
        repeat (6) @(negedge Clk);
        #1;
        nReset = 1'b0;
        exp_q.delete();
        hold_digits = '0;
        hold_ovf    = 1'b0;
        #1;
        check_eq("midrst_digits", 32'(Digits), 32'd0);
        check_eq("midrst_busy", 32'(Busy), 32'd0);
        check_eq("midrst_done", 32'(Done), 32'd0);
        check_eq("midrst_ovf", 32'(Overflow), 32'd0);
        @(negedge Clk);
        nReset = 1'b1;
        n0 = done_count;
        repeat (25) @(negedge Clk);
        #1;
        check_eq("no_done_after_rst", 32'(done_count - n0), 32'd0);
        run(8765, 1'b1);
        check_eq("d8765", 32'(Digits), 32'({5'd8, 5'd7, 5'd6, 5'd5}));

        // Boundary and random values
        run(16383, 1'b1);
        run(1, 1'b1);
        run(100, 1'b1);
        repeat (25) run($urandom_range(16383, 0), 1'($urandom));

        repeat (3) @(negedge Clk);
        #1;
        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/b_bcd_encoder.md
Name: b_bcd_encoder

Overview:
Sequential binary-to-digit-code encoder; the producer side of the seven-segment digit-code interface. It converts a binary value into DIGITS 5-bit digit codes by iterative double-dabble, one shift per clock. Each code is 0–9 for a decimal digit, 10 for a blank digit and 16 for 'E'. Outputs feed the per-digit seven-segment decoders directly; a Start/Busy/Done handshake lets the display controller request a new conversion.

Parameters:
WIDTH, 14, binary input width in bits (1..20)
DIGITS, 4, number of decimal digits produced (1..6)

Ports:
Clk  input  1  system clock, rising edge
nReset  input  1  asynchronous active-low reset
Value  input  WIDTH  unsigned binary value, sampled on the Start edge
Start  input  1  conversion request, sampled only while idle
BlankZeros  input  1  leading-zero blanking enable, sampled with Start
Digits  output  5*DIGITS  digit codes; [4:0]=units, [9:5]=tens, etc.
Busy  output  1  conversion in progress
Done  output  1  one-cycle pulse when Digits are updated
Overflow  output  1  last conversion exceeded 10^DIGITS-1

Behaviour:
- Reset (nReset low, asynchronous): Digits all 0 (display shows all zeros), Busy=0, Done=0, Overflow=0, FSM=IDLE, internal registers cleared. Reset mid-conversion aborts the conversion; no Done pulse is produced.
- FSM states: IDLE, CONVERT, FORMAT.
- IDLE, Start=1 at edge E0:
  - latch Value into the shift register; clear the BCD register (4*DIGITS bits) and the iteration counter;
  - latch BlankZeros;
  - latch ovf = (Value > 10^DIGITS-1);
  - Busy=1; go to CONVERT.
- CONVERT: one iteration per edge, WIDTH iterations (edges E1..E_WIDTH).
  - Each iteration: every BCD nibble ≥5 gets +3, then {BCD,shift} shifts left by 1.
  - Bits shifted out of the BCD MSB are discarded; they are only possible when ovf=1.
  - After iteration WIDTH, go to FORMAT.
- FORMAT, edge E_(WIDTH+1):
  - If ovf: every digit code = 16 and Overflow=1.
  - Else: digit i = BCD nibble i, Overflow=0. If the latched BlankZeros=1, every zero digit more significant than the most significant nonzero digit becomes code 10. The units digit is never blanked, so value 0 displays as one '0'.
  - On the same edge: update Digits, Done=1, Busy=0, go to IDLE.
- Latency: Done is high exactly WIDTH+1 edges after the Start edge (15 for defaults). Latency is fixed regardless of value or overflow.
- Done is high for one cycle only.
- Digits and Overflow hold their values until the next FORMAT edge or reset. They never change during CONVERT, so the display stays glitch-free.
- Start while Busy=1: ignored, with no effect on the conversion in progress.
- Start high in the Done cycle: FSM is already IDLE, so Start is accepted and a new conversion begins. Start held high produces back-to-back conversions every WIDTH+2 cycles.
- Value and BlankZeros may change freely after the Start edge.
- If 2^WIDTH-1 ≤ 10^DIGITS-1, Overflow never asserts.

Test Plan:
- Value=1234, BlankZeros=0, Start pulse → after 15 edges Done=1 for 1 cycle; Digits = {1,2,3,4} (MS→LS); Overflow=0; Busy high for cycles 1..15.
- Value=42, BlankZeros=1 → Digits={10,10,4,2}. Value=0, BlankZeros=1 → {10,10,10,0}. Value=0, BlankZeros=0 → {0,0,0,0}.
- Value=9999 → {9,9,9,9}, Overflow=0. Value=10000 → {16,16,16,16}, Overflow=1, same 15-cycle latency. Next Value=7 → Overflow returns to 0.
- Value=5678 started; Start with Value=1 asserted on cycle 5 → ignored; exactly one Done, Digits={5,6,7,8}. Start held high across Done → second conversion starts in the Done cycle; its Done comes 16 cycles after the first.
- nReset pulsed low at cycle 7 of a conversion → Digits=0, Busy=0, Done=0, Overflow=0 immediately; no Done afterwards; a fresh Start converts correctly.
- Random Values 0..16383 with random BlankZeros → Digits match the decimal reference model and the blanking rule; Digits stable between Done pulses.
